// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// reset/idle defaults and the PC-select codes driven by the PC mux.
package fetch_pkg;

  // Default PC after reset and the instruction shown while nothing is held.
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // Fetch FSM states. One request is outstanding at most.
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // presenting a request at pc
    ST_WAIT  = 2'd1,  // request accepted, waiting for the response
    ST_VALID = 2'd2,  // instruction held for decode
    ST_DROP  = 2'd3   // response still due but no longer wanted
  } fetch_state_e;

  // PC-select mux codes; anything other than sequential is a redirect.
  typedef enum logic [2:0] {
    PC_SEL_SEQ    = 3'b000,
    PC_SEL_BRANCH = 3'b001,
    PC_SEL_JAL    = 3'b010,
    PC_SEL_JALR   = 3'b011,
    PC_SEL_EXC    = 3'b100,
    PC_SEL_MRET   = 3'b111
  } pc_sel_e;

  // Redirect qualifier used by whoever drives the mux select.
  function automatic logic pc_sel_is_redirect(input pc_sel_e sel);
    return (sel != PC_SEL_SEQ);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: a request transfers on a rising clk edge where imem_req_valid
// and imem_req_ready are both high; imem_addr is stable while valid is high
// unless the fetch is redirected before acceptance. The memory answers each
// accepted request with exactly one single-cycle imem_rsp_valid pulse carrying
// imem_rsp_data; there is no backpressure on the response.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch unit side.
  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Instruction memory side.
  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Architectural PC register: loads d when load is high, resets to RESET_VAL.
module pc_register #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Hold the PC unless a new value is being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding fetches,
// delivers the instruction with its PC to decode, and cleanly discards
// fetches that a redirect has made stale.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  next_pc,
  input  logic         redirect,
  input  logic         stall,
  fetch_unit_if.master imem,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc,
  output logic         pc_misaligned,
  output fetch_state_e state_dbg
);

  fetch_state_e state;
  logic         pc_load;
  logic         req_accept;

  // The PC moves on any redirect, or when decode takes the held instruction.
  assign pc_load = redirect | ((state == ST_VALID) & ~stall);

  pc_register #(
    .RESET_VAL (RESET_PC)
  ) u_pc_register (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (next_pc),
    .q     (pc)
  );

  assign pc_plus4      = pc + 32'd4;
  assign pc_misaligned = (pc[1:0] != 2'b00);

  // A misaligned PC never reaches memory; the trap redirect recovers it.
  // Gating with rst_n keeps the request low while reset is asserted.
  assign imem.imem_req_valid = rst_n & (state == ST_REQ) & ~pc_misaligned;
  assign imem.imem_addr      = pc;
  assign req_accept          = imem.imem_req_valid & imem.imem_req_ready;

  assign state_dbg = state;

  // Fetch sequencing and the registered instruction/PC handed to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= RESET_PC;
    end else begin
      unique case (state)
        ST_REQ: begin
          // A redirect in the accept cycle leaves a response we must drop.
          if (req_accept) begin
            state <= redirect ? ST_DROP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (!redirect) begin
              if_instr <= imem.imem_rsp_data;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= ST_VALID;
            end else begin
              state <= ST_REQ;
            end
          end else if (redirect) begin
            state <= ST_DROP;
          end
        end
        ST_VALID: begin
          // Redirect flushes the held instruction even if decode is stalled.
          if (redirect) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            state    <= ST_REQ;
          end else if (!stall) begin
            if_valid <= 1'b0;
            state    <= ST_REQ;
          end
        end
        ST_DROP: begin
          // Further redirects only retarget pc; the stale response still ends DROP.
          if (imem.imem_rsp_valid) begin
            state <= ST_REQ;
          end
        end
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by a randomized run,
// with a behavioural memory and an architectural model of the fetch stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         stall;
  logic         redirect;
  logic [31:0]  next_pc;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic         pc_misaligned;
  fetch_state_e state_dbg;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .stall         (stall),
    .imem          (imem.master),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .pc_misaligned (pc_misaligned),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  int          delivered = 0;
  logic [31:0] exp_pc;      // address of the next instruction decode must see
  bit          mem_pend;    // memory owes a response
  int          mem_cnt;     // cycles until that response
  logic [31:0] mem_addr;
  int          force_lat;   // >=0 fixes memory latency, <0 randomizes it

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Drives inputs at the falling edge, lets them settle, then predicts what
  // the coming rising edge does and checks it against the model.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    if (mem_pend && mem_cnt == 0) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = mem_word(mem_addr);
      mem_pend = 1'b0;
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = 32'hDEAD_BEEF;
      if (mem_pend) mem_cnt--;
    end
    stall    = st;
    redirect = rd;
    next_pc  = rd ? tgt : exp_pc + 32'd4;
    imem.imem_req_ready = rdy;
    #1;
    chk("pc_plus4", pc_plus4, pc + 32'd4);
    if (imem.imem_req_valid && rdy) begin
      chk("req_addr", imem.imem_addr, exp_pc);
      chk("one_outstanding", {31'b0, mem_pend}, 32'd0);
      mem_pend = 1'b1;
      mem_addr = imem.imem_addr;
      mem_cnt  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 2));
    end
    if (if_valid && !st && !rd) begin
      chk("deliver_pc", if_pc, exp_pc);
      chk("deliver_instr", if_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (rd) exp_pc = tgt;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    stall = 1'b0;
    redirect = 1'b0;
    next_pc = 32'd0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'd0;
    exp_pc = RESET_PC;
    mem_pend = 1'b0;
    mem_cnt = 0;
    mem_addr = 32'd0;
    force_lat = 0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, NOP_INSTR);
    chk("rst_if_pc", if_pc, RESET_PC);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
    rst_n = 1'b1;

    // First fetch with zero-wait memory.
    step(0, 0, 0, 1);
    chk("first_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
    chk("first_addr", imem.imem_addr, 32'd0);
    step(0, 0, 0, 1);

    // Three stalled cycles holding the instruction.
    step(1, 0, 0, 1);
    chk("t1_if_valid", {31'b0, if_valid}, 32'd1);
    chk("t1_if_instr", if_instr, 32'h0050_0093);
    chk("t1_if_pc", if_pc, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 1);
      chk("stall_if_instr", if_instr, 32'h0050_0093);
      chk("stall_if_pc", if_pc, 32'd0);
      chk("stall_no_req", {31'b0, imem.imem_req_valid}, 32'd0);
    end
    step(0, 0, 0, 1);
    force_lat = 2;
    step(0, 0, 0, 1);
    chk("after_stall_pc", pc, 32'd4);
    chk("after_stall_addr", imem.imem_addr, 32'd4);
    chk("after_stall_req", {31'b0, imem.imem_req_valid}, 32'd1);

    // Redirect in WAIT; the late response must be discarded.
    step(0, 1, 32'h100, 1);
    step(0, 0, 0, 1);
    chk("drop_no_req", {31'b0, imem.imem_req_valid}, 32'd0);
    chk("drop_pc", pc, 32'h100);
    step(0, 0, 0, 1);
    chk("drop_if_valid", {31'b0, if_valid}, 32'd0);
    force_lat = 0;
    step(0, 0, 0, 1);
    chk("redir_addr", imem.imem_addr, 32'h100);
    chk("redir_req", {31'b0, imem.imem_req_valid}, 32'd1);
    step(0, 0, 0, 1);

    // Redirect to a misaligned PC, then recover via a second redirect.
    step(0, 1, 32'h2, 1);
    chk("v100_if_pc", if_pc, 32'h100);
    step(0, 0, 0, 1);
    chk("mis_flag", {31'b0, pc_misaligned}, 32'd1);
    chk("mis_no_req", {31'b0, imem.imem_req_valid}, 32'd0);
    chk("mis_if_instr_nop", if_instr, NOP_INSTR);
    step(0, 1, 32'h80, 1);
    chk("mis_hold_no_req", {31'b0, imem.imem_req_valid}, 32'd0);
    step(0, 0, 0, 1);
    chk("recover_aligned", {31'b0, pc_misaligned}, 32'd0);
    chk("recover_addr", imem.imem_addr, 32'h80);
    step(0, 0, 0, 1);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 1);
    chk("v80_if_pc", if_pc, 32'h80);
    step(0, 0, 0, 1);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'd0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("wrapped_pc", pc, 32'd0);
    step(0, 0, 0, 1);

    // Reset in the middle of WAIT; the stale response arrives afterwards.
    step(0, 1, 32'h200, 1);
    force_lat = 2;
    step(0, 0, 0, 1);
    chk("pre_rst_addr", imem.imem_addr, 32'h200);
    step(0, 0, 0, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_pc", pc, RESET_PC);
    chk("mid_rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_rst_req", {31'b0, imem.imem_req_valid}, 32'd0);
    chk("mid_rst_if_instr", if_instr, NOP_INSTR);
    imem.imem_req_ready = 1'b0;
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    force_lat = 0;
    step(0, 0, 0, 0);
    chk("post_rst_req", {31'b0, imem.imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem.imem_addr, RESET_PC);
    step(0, 0, 0, 0);
    chk("stale_rsp_ignored", {31'b0, if_valid}, 32'd0);
    chk("stale_req_held", {31'b0, imem.imem_req_valid}, 32'd1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("fresh_if_valid", {31'b0, if_valid}, 32'd1);
    chk("fresh_if_instr", if_instr, 32'h0050_0093);
    chk("fresh_if_pc", if_pc, RESET_PC);

    // Randomized run: random ready, latency, stalls and aligned redirects.
    force_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic        r_st;
      logic        r_rd;
      logic        r_rdy;
      logic [31:0] r_tgt;
      r_st  = ($urandom_range(0, 2) == 0);
      r_rd  = ($urandom_range(0, 11) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_tgt = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      step(r_st, r_rd, r_tgt, r_rdy);
    end
    chk("enough_deliveries", {31'b0, (delivered > 200)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
